// File: rtl/prop_flag_monitor.sv
// prop_flag_monitor: sticky latch, first-hit cycle stamp and one-at-a-time
// valid/ready reporting for the benchmark property flags (bit0=z1 .. bit3=z4).
// Optional per-flag saturating hit counters are built when PFM_HIT_COUNT_EN
// is defined; the default build has no hit_cnt port.
module prop_flag_monitor #(
  parameter int unsigned NFLAG     = 4,
  parameter int unsigned IW        = 2,
  parameter int unsigned CW        = 16,
  parameter int unsigned ARM_DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NFLAG-1:0] flag_in,
  input  logic             clr,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [IW-1:0]    rpt_id,
  output logic [CW-1:0]    rpt_cycle,
  output logic [NFLAG-1:0] sticky,
  output logic             busy
`ifdef PFM_HIT_COUNT_EN
  ,
  output logic [NFLAG*8-1:0] hit_cnt
`endif
);

  localparam int unsigned   AW       = $clog2(ARM_DELAY + 1) + 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_DELAY);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REPORT
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    arm_q, arm_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [NFLAG-1:0] sticky_q, sticky_d;
  logic [NFLAG-1:0] pending_q, pending_d;
  logic [CW-1:0]    stamp_q [NFLAG];
  logic [CW-1:0]    stamp_d [NFLAG];
  logic             rpt_valid_q, rpt_valid_d;
  logic [IW-1:0]    rpt_id_q, rpt_id_d;
  logic [CW-1:0]    rpt_cycle_q, rpt_cycle_d;

  logic             armed;
  logic [NFLAG-1:0] new_hits;
  logic [NFLAG-1:0] pend_all;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             can_load;

  // With ARM_DELAY=0 the IDLE state already observes flags.
  assign armed = (state_q != IDLE) || (ARM_DELAY == 0);

  // Next-state: arming, sampling, stamping, report selection and clear
  always_comb begin
    state_d     = state_q;
    arm_d       = arm_q;
    cyc_d       = cyc_q;
    sticky_d    = sticky_q;
    pending_d   = pending_q;
    stamp_d     = stamp_q;
    rpt_valid_d = rpt_valid_q;
    rpt_id_d    = rpt_id_q;
    rpt_cycle_d = rpt_cycle_q;
    new_hits    = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    can_load    = 1'b0;

    if (armed && en) begin
      new_hits = flag_in & ~sticky_q;
      if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
    end
    for (int unsigned i = 0; i < NFLAG; i++) begin
      if (new_hits[i]) stamp_d[i] = cyc_q;
    end
    sticky_d = sticky_q | new_hits;
    pend_all = pending_q | new_hits;
    pending_d = pend_all;

    // Descending scan so the lowest set index wins.
    for (int unsigned i = NFLAG; i > 0; i--) begin
      if (pend_all[i-1]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i - 1);
      end
    end

    case (state_q)
      IDLE: begin
        if (ARM_DELAY == 0) begin
          can_load = 1'b1;
          state_d  = ARMED;
        end else if (en) begin
          arm_d = arm_q + 1'b1;
          if (arm_d == ARM_LAST) state_d = ARMED;
        end
      end
      ARMED: can_load = 1'b1;
      REPORT: begin
        if (rpt_ready) begin
          can_load = 1'b1;
          if (!sel_found) begin
            rpt_valid_d = 1'b0;
            state_d     = ARMED;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (can_load && sel_found) begin
      rpt_valid_d        = 1'b1;
      rpt_id_d           = sel_idx;
      rpt_cycle_d        = stamp_d[sel_idx];
      pending_d[sel_idx] = 1'b0;
      state_d            = REPORT;
    end

    // Clear overrides sampling and handshake; arming progress is kept.
    if (clr) begin
      sticky_d    = '0;
      pending_d   = '0;
      cyc_d       = '0;
      rpt_valid_d = 1'b0;
      rpt_id_d    = '0;
      rpt_cycle_d = '0;
      for (int unsigned i = 0; i < NFLAG; i++) stamp_d[i] = '0;
      if (state_d == REPORT) state_d = ARMED;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      arm_q       <= '0;
      cyc_q       <= '0;
      sticky_q    <= '0;
      pending_q   <= '0;
      rpt_valid_q <= 1'b0;
      rpt_id_q    <= '0;
      rpt_cycle_q <= '0;
      for (int unsigned i = 0; i < NFLAG; i++) stamp_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      cyc_q       <= cyc_d;
      sticky_q    <= sticky_d;
      pending_q   <= pending_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_id_q    <= rpt_id_d;
      rpt_cycle_q <= rpt_cycle_d;
      for (int unsigned i = 0; i < NFLAG; i++) stamp_q[i] <= stamp_d[i];
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_id    = rpt_id_q;
  assign rpt_cycle = rpt_cycle_q;
  assign sticky    = sticky_q;
  assign busy      = (|pending_q) | rpt_valid_q;

`ifdef PFM_HIT_COUNT_EN
  logic [7:0] hit_q [NFLAG];
  logic [7:0] hit_d [NFLAG];

  // Count every armed, enabled cycle a flag is high, saturating at 255
  always_comb begin
    for (int unsigned i = 0; i < NFLAG; i++) begin
      hit_d[i] = hit_q[i];
      if (armed && en && flag_in[i] && (hit_q[i] != 8'hFF)) hit_d[i] = hit_q[i] + 8'd1;
      if (clr) hit_d[i] = '0;
    end
  end

  // Hit counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NFLAG; i++) hit_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NFLAG; i++) hit_q[i] <= hit_d[i];
    end
  end

  // Pack counters onto the flat output
  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < NFLAG; i++) hit_cnt[i*8 +: 8] = hit_q[i];
  end
`endif

endmodule

// File: tb/tb_prop_flag_monitor.sv
// Directed bench for prop_flag_monitor with a per-edge reference model.
module tb_prop_flag_monitor;

  localparam int ARM_DELAY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  flag_in = '0;
  logic        clr = 1'b0;
  logic        rpt_ready = 1'b0;
  logic        rpt_valid;
  logic [1:0]  rpt_id;
  logic [15:0] rpt_cycle;
  logic [3:0]  sticky;
  logic        busy;
`ifdef PFM_HIT_COUNT_EN
  logic [31:0] hit_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  prop_flag_monitor #(
    .NFLAG(4),
    .IW(2),
    .CW(16),
    .ARM_DELAY(ARM_DELAY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .flag_in(flag_in),
    .clr(clr),
    .rpt_ready(rpt_ready),
    .rpt_valid(rpt_valid),
    .rpt_id(rpt_id),
    .rpt_cycle(rpt_cycle),
    .sticky(sticky),
    .busy(busy)
`ifdef PFM_HIT_COUNT_EN
    ,
    .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: plain integers and bit sets, updated once per rising edge
  int       m_arm;
  bit       m_armed;
  int       m_cyc;
  bit [3:0] m_sticky;
  bit [3:0] m_pend;
  int       m_stamp[4];
  bit       m_valid;
  int       m_id;
  int       m_cycle;
  int       m_hit[4];

  task automatic model_reset();
    m_arm = 0; m_armed = 0; m_cyc = 0; m_sticky = '0; m_pend = '0;
    m_valid = 0; m_id = 0; m_cycle = 0;
    for (int i = 0; i < 4; i++) begin m_stamp[i] = 0; m_hit[i] = 0; end
  endtask

  task automatic model_edge();
    bit       was_armed;
    bit [3:0] nh;
    bit       found;
    if (!reset) begin model_reset(); return; end
    was_armed = m_armed;
    nh = '0;
    if (!was_armed) begin
      if (en) begin
        m_arm++;
        if (m_arm == ARM_DELAY) m_armed = 1;
      end
    end else if (en) begin
      nh = flag_in & ~m_sticky;
      for (int i = 0; i < 4; i++) begin
        if (nh[i]) m_stamp[i] = m_cyc;
        if (flag_in[i] && m_hit[i] < 255) m_hit[i]++;
      end
      if (m_cyc < 65535) m_cyc++;
    end
    m_sticky = m_sticky | nh;
    m_pend   = m_pend | nh;
    if (was_armed && (!m_valid || rpt_ready)) begin
      m_valid = 0;
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && m_pend[i]) begin
          found = 1; m_valid = 1; m_id = i; m_cycle = m_stamp[i]; m_pend[i] = 0;
        end
      end
    end
    if (clr) begin
      m_sticky = '0; m_pend = '0; m_cyc = 0; m_valid = 0;
      for (int i = 0; i < 4; i++) begin m_stamp[i] = 0; m_hit[i] = 0; end
    end
  endtask

  initial model_reset();

  // Compare process: advance the model at each edge, check DUT just after
  always @(posedge clk) begin
    model_edge();
    #1;
    chk("valid", 32'(rpt_valid), 32'(m_valid));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("busy", 32'(busy), 32'((m_pend != 0) || m_valid));
    if (m_valid) begin
      chk("id", 32'(rpt_id), 32'(m_id));
      chk("cycle", 32'(rpt_cycle), 32'(m_cycle));
    end
`ifdef PFM_HIT_COUNT_EN
    for (int i = 0; i < 4; i++) chk("hit", 32'(hit_cnt[i*8 +: 8]), 32'(m_hit[i]));
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rpt_valid), 0);
    chk("rst_id", 32'(rpt_id), 0);
    chk("rst_cycle", 32'(rpt_cycle), 0);
    chk("rst_sticky", 32'(sticky), 0);
    chk("rst_busy", 32'(busy), 0);

    // Arming window ignores flags; cycle-5 sample stamps cyc=3
    reset = 1'b1; en = 1'b1; flag_in = 4'b0001; rpt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arm_ignore", 32'(sticky), 0);
    flag_in = 4'b0000;
    repeat (3) @(negedge clk);
    flag_in = 4'b0001;
    @(negedge clk);
    chk("t1_valid", 32'(rpt_valid), 1);
    chk("t1_id", 32'(rpt_id), 0);
    chk("t1_cycle", 32'(rpt_cycle), 3);
    chk("t1_sticky", 32'(sticky), 4'b0001);
    rpt_ready = 1'b1;
    repeat (4) @(negedge clk);  // flag held high: exactly one report
    chk("t1_once", 32'(rpt_valid), 0);

    // Two flags on one edge at cyc=7: ascending back-to-back reports
    flag_in = 4'b0000; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (7) @(negedge clk);
    flag_in = 4'b1010;
    @(negedge clk);
    flag_in = 4'b0000;
    chk("t2_id_a", 32'(rpt_id), 1);
    chk("t2_cyc_a", 32'(rpt_cycle), 7);
    chk("t2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t2_valid_b", 32'(rpt_valid), 1);
    chk("t2_id_b", 32'(rpt_id), 3);
    chk("t2_cyc_b", 32'(rpt_cycle), 7);
    @(negedge clk);
    chk("t2_idle", 32'(busy), 0);

    // Stall for 5 cycles with flag2 rising during the stall
    rpt_ready = 1'b0; flag_in = 4'b0001;
    @(negedge clk);
    flag_in = 4'b0101;
    repeat (5) @(negedge clk);
    chk("t3_hold_id", 32'(rpt_id), 0);
    rpt_ready = 1'b1; flag_in = 4'b0000;
    @(negedge clk);
    chk("t3_next_valid", 32'(rpt_valid), 1);
    chk("t3_next_id", 32'(rpt_id), 2);
    @(negedge clk);

    // Clear on the same edge a flag rises, then fresh sample at cyc 0
    rpt_ready = 1'b0; clr = 1'b1; flag_in = 4'b0001;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_noreport", 32'(rpt_valid), 0);
    chk("t4_sticky", 32'(sticky), 0);
    @(negedge clk);
    chk("t4_valid", 32'(rpt_valid), 1);
    chk("t4_id", 32'(rpt_id), 0);
    chk("t4_cycle", 32'(rpt_cycle), 0);

    // Queue flag3, then disable for 10 cycles while reports drain
    flag_in = 4'b1001;
    @(negedge clk);
    en = 1'b0; rpt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      flag_in = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    chk("t5_sticky", 32'(sticky), 4'b1001);
    chk("t5_drained", 32'(busy), 0);
    en = 1'b1; flag_in = 4'b0010;
    @(negedge clk);
    chk("t5_frozen_cyc", 32'(rpt_cycle), 2);
    chk("t5_id", 32'(rpt_id), 1);

    // Asynchronous reset mid-cycle while a report is valid
    rpt_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(rpt_valid), 0);
    chk("ar_id", 32'(rpt_id), 0);
    chk("ar_cycle", 32'(rpt_cycle), 0);
    chk("ar_sticky", 32'(sticky), 0);
    chk("ar_busy", 32'(busy), 0);
    flag_in = 4'b0000;
    @(negedge clk);
    reset = 1'b1;

`ifdef PFM_HIT_COUNT_EN
    // Arm, then hold flag1 for 300 armed cycles: counter saturates
    rpt_ready = 1'b1;
    repeat (ARM_DELAY) @(negedge clk);
    flag_in = 4'b0010;
    repeat (300) @(negedge clk);
    chk("hit_sat", 32'(hit_cnt[15:8]), 255);
    chk("hit_other", 32'(hit_cnt[7:0]), 0);
    flag_in = 4'b0000;
`endif
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
